// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue/result sequencer wrapped around the 8-bit combinational ALU.
// Optional golden-model cross-check of ALU results is enabled by defining ALU_SELFCHECK_EN.
module alu_cmd_sequencer #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_co,
  input  logic [15:0] alu_q,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [2:0]  res_op,
  output logic        res_err,
  output logic        busy
`ifdef ALU_SELFCHECK_EN
  ,
  output logic        res_mismatch,
  output logic [7:0]  mismatch_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ISSUE  = 2'b01;
  localparam logic [1:0] RESULT = 2'b10;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [18:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [1:0]       state;
  logic             empty;
  logic             push;
  logic             pop;
  logic [7:0]       head_a;
  logic [7:0]       head_b;
  logic [2:0]       head_op;

  function automatic logic op_defined(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

`ifdef ALU_SELFCHECK_EN
  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
    logic [15:0] q;
    case (op)
      3'd1:    q = {15'd0, a[0]};
      3'd2:    q = {3'd0, a, 5'd0};
      3'd3:    q = 16'(a) * 16'd55 + 16'(b);
      3'd4:    q = (a < b) ? 16'(a) : 16'(b);
      3'd5:    q = (16'(a) + 16'(b)) << 9;
      default: q = 16'd0;
    endcase
    return q;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  assign empty     = (count == '0);
  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign busy      = !empty || (state != IDLE);
  assign {head_op, head_b, head_a} = mem[rd_ptr];

  // RESULT always has res_valid high, so a pop there is exactly a result handshake.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      RESULT:  pop = res_ready && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_b, cmd_a};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_co    <= 3'b000;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      res_err   <= 1'b0;
`ifdef ALU_SELFCHECK_EN
      res_mismatch <= 1'b0;
      mismatch_cnt <= '0;
`endif
    end else if (state == ISSUE) begin
      // Settle cycle over: capture the ALU output and park the opcode at 000.
      res_data  <= alu_q;
      res_op    <= alu_co;
      res_err   <= 1'b0;
      res_valid <= 1'b1;
      alu_co    <= 3'b000;
      state     <= RESULT;
`ifdef ALU_SELFCHECK_EN
      res_mismatch <= (alu_model(alu_a, alu_b, alu_co) != alu_q);
      if (alu_model(alu_a, alu_b, alu_co) != alu_q) mismatch_cnt <= sat_inc(mismatch_cnt);
`endif
    end else if (pop) begin
      if (op_defined(head_op)) begin
        alu_a     <= head_a;
        alu_b     <= head_b;
        alu_co    <= head_op;
        res_valid <= 1'b0;
        state     <= ISSUE;
      end else begin
        res_data  <= '0;
        res_op    <= head_op;
        res_err   <= 1'b1;
        res_valid <= 1'b1;
        state     <= RESULT;
`ifdef ALU_SELFCHECK_EN
        res_mismatch <= 1'b0;
`endif
      end
    end else if (state == RESULT && res_ready) begin
      res_valid <= 1'b0;
      state     <= IDLE;
    end else if (state != IDLE && state != RESULT) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed-vector bench for alu_cmd_sequencer; includes a behavioural model of the attached ALU.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_co;
  logic [15:0] alu_q;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [2:0]  res_op;
  logic        res_err;
  logic        busy;
`ifdef ALU_SELFCHECK_EN
  logic        res_mismatch;
  logic [7:0]  mismatch_cnt;
`endif

  int n_vec = 0;
  int n_miss = 0;
  int co_cycles = 0;
  int rv_cycles = 0;
  logic [2:0] co_seen = '0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_co(alu_co), .alu_q(alu_q),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_err(res_err),
    .busy(busy)
`ifdef ALU_SELFCHECK_EN
    , .res_mismatch(res_mismatch), .mismatch_cnt(mismatch_cnt)
`endif
  );

  // The combinational ALU the sequencer drives.
  always_comb begin
    alu_q = 16'd0;
    case (alu_co)
      3'd1: alu_q = {15'd0, alu_a[0]};
      3'd2: alu_q = {3'd0, alu_a, 5'd0};
      3'd3: alu_q = 16'(alu_a) * 16'd55 + 16'(alu_b);
      3'd4: alu_q = (alu_a < alu_b) ? 16'(alu_a) : 16'(alu_b);
      3'd5: alu_q = (16'(alu_a) + 16'(alu_b)) << 9;
      default: alu_q = 16'd0;
    endcase
  end

  always @(negedge clk) begin
    if (alu_co != 3'b000) begin
      co_cycles = co_cycles + 1;
      co_seen = alu_co;
    end
    if (res_valid) rv_cycles = rv_cycles + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_data, input logic exp_err, input int exp_lat,
                         input string tag);
    int cyc;
    int co0;
    co0 = co_cycles;
    res_ready = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 1;
    while (!res_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_vec({tag, "_lat"}, cyc, exp_lat);
    check_vec({tag, "_data"}, res_data, exp_data);
    check_vec({tag, "_op"}, res_op, op);
    check_vec({tag, "_err"}, res_err, exp_err);
    @(posedge clk); #1;
    check_vec({tag, "_hold"}, {res_valid, res_data}, {1'b1, exp_data});
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_vec({tag, "_co_cycles"}, co_cycles - co0, exp_err ? 0 : 1);
    if (!exp_err) check_vec({tag, "_co_val"}, co_seen, op);
    check_vec({tag, "_idle"}, {res_valid, busy}, 2'b00);
  endtask

  initial begin
    int acc;
    int nres;
    int rv0;
    logic [15:0] got_data [8];
    logic [2:0]  got_op [8];
    logic        got_err [8];

    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_res", {res_valid, res_err, res_op, res_data}, 0);
    check_vec("rst_alu", {alu_a, alu_b, alu_co}, 0);
    check_vec("rst_rdy", cmd_ready, 1);
    check_vec("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(3'd1, 8'd7,   8'd0,   16'd1,      1'b0, 3, "par7");
    run_cmd(3'd1, 8'd8,   8'd0,   16'd0,      1'b0, 3, "par8");
    run_cmd(3'd3, 8'd10,  8'd3,   16'd553,    1'b0, 3, "mac");
    run_cmd(3'd2, 8'd255, 8'd0,   16'h1FE0,   1'b0, 3, "shl");
    run_cmd(3'd4, 8'd5,   8'd9,   16'd5,      1'b0, 3, "min59");
    run_cmd(3'd4, 8'd4,   8'd4,   16'd4,      1'b0, 3, "min44");
    run_cmd(3'd5, 8'd200, 8'd100, 16'h5800,   1'b0, 3, "addsh");
    run_cmd(3'd6, 8'd12,  8'd34,  16'd0,      1'b1, 2, "bad6");

    // Fill with the consumer stalled: one command parks in RESULT, four queue.
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op = (i == 2) ? 3'd7 : 3'd4;
      cmd_a = 8'(10 + i);
      cmd_b = 8'd200;
      if (cmd_ready) acc++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check_vec("fill_acc", acc, 5);
    check_vec("fill_rdy", cmd_ready, 0);
    check_vec("fill_busy", busy, 1);
    res_ready = 1'b1;
    nres = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      if (res_valid) begin
        if (nres < 8) begin
          got_data[nres] = res_data;
          got_op[nres] = res_op;
          got_err[nres] = res_err;
        end
        nres++;
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    check_vec("drain_cnt", nres, 5);
    check_vec("drain_busy", busy, 0);
    check_vec("drain_rdy", cmd_ready, 1);
    check_vec("drain_r0", {got_err[0], got_op[0], got_data[0]}, {1'b0, 3'd4, 16'd10});
    check_vec("drain_r1", {got_err[1], got_op[1], got_data[1]}, {1'b0, 3'd4, 16'd11});
    check_vec("drain_r2", {got_err[2], got_op[2], got_data[2]}, {1'b1, 3'd7, 16'd0});
    check_vec("drain_r3", {got_err[3], got_op[3], got_data[3]}, {1'b0, 3'd4, 16'd13});
    check_vec("drain_r4", {got_err[4], got_op[4], got_data[4]}, {1'b0, 3'd4, 16'd14});

    // Reset in the middle of ISSUE with three commands still queued.
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 3'd3;
      cmd_a = 8'(i + 1);
      cmd_b = 8'd1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_vec("mid_issue_co", alu_co, 3'd3);
    check_vec("mid_issue_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check_vec("arst_res", {res_valid, res_err, res_op, res_data}, 0);
    check_vec("arst_alu", {alu_a, alu_b, alu_co}, 0);
    check_vec("arst_ctl", {cmd_ready, busy}, 2'b10);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    rv0 = rv_cycles;
    res_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    res_ready = 1'b0;
    check_vec("post_no_stale", rv_cycles - rv0, 0);
    check_vec("post_empty", {busy, cmd_ready}, 2'b01);
    run_cmd(3'd3, 8'd2, 8'd7, 16'd117, 1'b0, 3, "post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1);
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequential front/back end for the 8-bit combinational ALU (`main`: ports a, b, co, q).
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a FIFO.
- Presents each command to the ALU stable for one settle cycle, registers the 16-bit q, and returns it over a valid/ready result handshake.
- Never drives an undefined opcode into the ALU; undefined opcodes are rejected with an error flag.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH): FIFO pointer width (derived, not overridden).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_a  in  8  operand a.
- cmd_b  in  8  operand b.
- cmd_op  in  3  opcode.
- alu_a  out  8  to ALU a.
- alu_b  out  8  to ALU b.
- alu_co  out  3  to ALU co.
- alu_q  in  16  from ALU q.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_data  out  16  result.
- res_op  out  3  opcode of this result.
- res_err  out  1  opcode was undefined.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: FIFO empty, FSM=IDLE, res_valid=0, res_data=0, res_op=0, res_err=0, alu_a=0, alu_b=0, alu_co=3'b000, cmd_ready=1, busy=0.
- Push: occurs when cmd_valid && cmd_ready. cmd_ready = !full, registered-count based. Push when full is impossible by construction. Simultaneous push and pop on a full FIFO is not permitted, because cmd_ready is already 0.
- Valid opcodes: 001 parity (q = a[0]), 010 a<<5 (16-bit), 011 a*55+b (mod 2^16), 100 min(a,b), 101 (a+b)<<9 (mod 2^16). Opcodes 000, 110 and 111 are undefined.
- FSM IDLE: if FIFO non-empty, pop the head.
  - Valid op: load alu_a/alu_b/alu_co from the head → ISSUE.
  - Undefined op: res_data=0, res_err=1, res_op=op, res_valid=1 → RESULT. alu_co stays 000.
- FSM ISSUE (exactly one cycle, the settle cycle): at its end register res_data=alu_q, res_op=alu_co, res_err=0, res_valid=1; drive alu_co=000 → RESULT.
- FSM RESULT: hold res_* stable while res_valid && !res_ready.
  - On handshake with FIFO non-empty: pop and load the next command in the same cycle (→ ISSUE, or stay in RESULT with a new error result).
  - On handshake with FIFO empty: res_valid=0 → IDLE.
- Latency: a command pushed into an empty FIFO in cycle N gives res_valid=1 in cycle N+3 (pop at N+1, issue at N+2, result at N+3).
- Throughput: one valid-op result per 2 cycles with res_ready held high; one error result per cycle.
- alu_a/alu_b hold their last values when not issuing. alu_co is nonzero only in ISSUE.
- FIFO pointers wrap modulo DEPTH. Ordering is strict FIFO.
- Reset asserted mid-operation: all state is cleared asynchronously, queued commands are discarded, and no result is emitted.

Optional Feature:
- Macro: ALU_SELFCHECK_EN.
- Defined:
  - An internal golden model computes the expected q from the issued operands.
  - Output port res_mismatch (1 bit) is valid with res_*.
  - Output port mismatch_cnt (8 bits) is sticky and saturates at 255; reset value 0.
  - The model is not evaluated for error results.
- Undefined: neither port exists and no model logic is synthesized.

Test Plan:
- op=001, a=7 → res_data=1; then a=8 → res_data=0. Latency from push into an empty FIFO is exactly 3 cycles.
- op=011, a=10, b=3 → 553. op=010, a=255 → 0x1FE0. op=100: a=5, b=9 → 5; a=b=4 → 4.
- op=101, a=200, b=100 → 0x5800. alu_co equals 101 for exactly one cycle.
- op=110 → res_err=1, res_data=0, res_op=110. alu_co never leaves 000 during this command.
- DEPTH=4, res_ready=0, push 6 commands back-to-back → 5 accepted (1 in RESULT plus 4 queued) and cmd_ready=0. Then raise res_ready → 5 results in push order, busy drops after the last.
- Assert rst_n=0 during ISSUE with 3 commands queued → all outputs at reset values immediately. After release: no stale result, FIFO empty, and the next push completes normally.
